// File: rtl/paint_shape_ctrl.sv
// Paint controller: collects one or two corner points from the switches, then
// rasterises a free pixel, filled box, box outline or full-screen clear as one pixel per cycle.
module paint_shape_ctrl #(
  parameter int X_W      = 8,
  parameter int Y_W      = 7,
  parameter int COLOUR_W = 3,
  parameter int X_MAX    = 159,
  parameter int Y_MAX    = 119
) (
  input  logic                Clock,
  input  logic                Reset,
  input  logic                go,
  input  logic [X_W-1:0]      coord_in,
  input  logic [1:0]          mode,
  input  logic [COLOUR_W-1:0] colour_in,
  output logic [X_W-1:0]      x,
  output logic [Y_W-1:0]      y,
  output logic [COLOUR_W-1:0] colour,
  output logic                plot,
  output logic                busy,
  output logic                done,
  output logic [2:0]          state_out
);

  typedef enum logic [2:0] {
    LOAD_X1 = 3'd0,
    LOAD_Y1 = 3'd1,
    LOAD_X2 = 3'd2,
    LOAD_Y2 = 3'd3,
    DRAW    = 3'd4,
    DONE    = 3'd5
  } state_t;

  typedef enum logic [1:0] {
    M_FREE    = 2'd0,
    M_FILL    = 2'd1,
    M_OUTLINE = 2'd2,
    M_CLEAR   = 2'd3
  } mode_t;

  localparam logic [X_W-1:0] XM    = X_W'(X_MAX);
  localparam logic [Y_W-1:0] YM    = Y_W'(Y_MAX);
  localparam logic [X_W-1:0] X_ONE = X_W'(1);
  localparam logic [Y_W-1:0] Y_ONE = Y_W'(1);

  state_t         state, state_n;
  mode_t          mode_r;
  logic [X_W-1:0] x1, x2, xa, xb;
  logic [Y_W-1:0] y1, y2, ya, yb;

  logic           start, last, edge_n;
  logic [X_W-1:0] x_clamp, bxa, bxb, x_n;
  logic [Y_W-1:0] y_clamp, bya, byb, y_n;

  assign state_out = state;

  always_ff @(posedge Clock) begin
    if (Reset) state <= LOAD_X1;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    start   = 1'b0;
    bxa     = '0;
    bxb     = '0;
    bya     = '0;
    byb     = '0;
    x_clamp = (coord_in > XM) ? XM : coord_in;
    y_clamp = (coord_in[Y_W-1:0] > YM) ? YM : coord_in[Y_W-1:0];
    last    = (x == xb) && (y == yb);
    if (x == xb) begin
      x_n = xa;
      y_n = y + Y_ONE;
    end else begin
      x_n = x + X_ONE;
      y_n = y;
    end
    edge_n = (mode_r != M_OUTLINE) || (x_n == xa) || (x_n == xb) ||
             (y_n == ya) || (y_n == yb);

    case (state)
      LOAD_X1: if (go) state_n = LOAD_Y1;
      LOAD_Y1: begin
        if (go) begin
          if (mode_r == M_FREE) begin
            state_n = DRAW;
            start   = 1'b1;
            bxa     = x1;
            bxb     = x1;
            bya     = y_clamp;
            byb     = y_clamp;
          end else if (mode_r == M_CLEAR) begin
            state_n = DRAW;
            start   = 1'b1;
            bxb     = XM;
            byb     = YM;
          end else begin
            state_n = LOAD_X2;
          end
        end
      end
      LOAD_X2: if (go) state_n = LOAD_Y2;
      LOAD_Y2: begin
        if (go) begin
          // y2 is still being latched, so the box uses the clamped switch value directly
          state_n = DRAW;
          start   = 1'b1;
          bxa     = (x1 < x2) ? x1 : x2;
          bxb     = (x1 < x2) ? x2 : x1;
          bya     = (y1 < y_clamp) ? y1 : y_clamp;
          byb     = (y1 < y_clamp) ? y_clamp : y1;
        end
      end
      DRAW:    if (last) state_n = DONE;
      DONE:    state_n = LOAD_X1;
      default: state_n = LOAD_X1;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      x1     <= '0;
      y1     <= '0;
      x2     <= '0;
      y2     <= '0;
      xa     <= '0;
      xb     <= '0;
      ya     <= '0;
      yb     <= '0;
      mode_r <= M_FREE;
      x      <= '0;
      y      <= '0;
      colour <= '0;
      plot   <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      case (state)
        LOAD_X1: if (go) begin
          x1     <= x_clamp;
          mode_r <= mode_t'(mode);
        end
        LOAD_Y1: if (go) y1 <= y_clamp;
        LOAD_X2: if (go) x2 <= x_clamp;
        LOAD_Y2: if (go) y2 <= y_clamp;
        DRAW: begin
          if (last) begin
            plot <= 1'b0;
            busy <= 1'b0;
            done <= 1'b1;
          end else begin
            x    <= x_n;
            y    <= y_n;
            plot <= edge_n;
          end
        end
        DONE:    done <= 1'b0;
        default: ;
      endcase
      // first scan position is presented in the very first DRAW cycle
      if (start) begin
        colour <= colour_in;
        xa     <= bxa;
        xb     <= bxb;
        ya     <= bya;
        yb     <= byb;
        x      <= bxa;
        y      <= bya;
        plot   <= 1'b1;
        busy   <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_paint_shape_ctrl.sv
// Directed self-checking bench for paint_shape_ctrl: each shape mode, clamping,
// reset during a draw and input changes while drawing.
module tb_paint_shape_ctrl;

  logic       Clock = 1'b0;
  logic       Reset;
  logic       go;
  logic [7:0] coord_in;
  logic [1:0] mode;
  logic [2:0] colour_in;
  logic [7:0] x;
  logic [6:0] y;
  logic [2:0] colour;
  logic       plot, busy, done;
  logic [2:0] state_out;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  logic [14:0] pix_q[$];
  int unsigned busy_cnt;
  int unsigned col_err;
  bit          saw_done;

  paint_shape_ctrl #(
    .X_W(8), .Y_W(7), .COLOUR_W(3), .X_MAX(159), .Y_MAX(119)
  ) dut (
    .Clock(Clock), .Reset(Reset), .go(go), .coord_in(coord_in), .mode(mode),
    .colour_in(colour_in), .x(x), .y(y), .colour(colour), .plot(plot),
    .busy(busy), .done(done), .state_out(state_out)
  );

  always #5 Clock = ~Clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  task automatic pulse_go(input logic [7:0] c, input logic [1:0] m);
    coord_in = c;
    mode     = m;
    go       = 1'b1;
    step();
    go       = 1'b0;
  endtask

  task automatic do_reset();
    Reset = 1'b1;
    step();
    step();
    Reset = 1'b0;
  endtask

  // Records every plotted pixel until done; poke drives go/mode/colour_in while drawing.
  task automatic capture(input int unsigned budget, input logic [2:0] exp_col, input bit poke);
    pix_q.delete();
    busy_cnt = 0;
    col_err  = 0;
    saw_done = 0;
    for (int unsigned i = 0; i < budget; i++) begin
      if (done) begin
        saw_done = 1;
        break;
      end
      if (busy) busy_cnt++;
      if (plot) begin
        pix_q.push_back({x, y});
        if (colour !== exp_col) col_err++;
      end
      if (poke) begin
        go        = ~go;
        mode      = 2'b11;
        colour_in = 3'b111;
      end
      step();
    end
    go = 1'b0;
    check("done_seen", 32'(saw_done), 32'd1);
  endtask

  initial begin
    int unsigned interior;
    int unsigned extra;
    logic [14:0] fill_exp [6];

    Reset = 1'b1; go = 1'b0; coord_in = '0; mode = '0; colour_in = '0;
    do_reset();
    check("rst_state", 32'(state_out), 32'd0);
    check("rst_plot",  32'(plot), 32'd0);
    check("rst_busy",  32'(busy), 32'd0);
    check("rst_done",  32'(done), 32'd0);
    check("rst_xy",    32'({x, y}), 32'd0);
    check("rst_col",   32'(colour), 32'd0);

    // FREE single pixel
    colour_in = 3'b101;
    pulse_go(8'd10, 2'b00);
    check("free_ly1", 32'(state_out), 32'd1);
    pulse_go(8'd20, 2'b00);
    capture(10, 3'b101, 0);
    check("free_npix", pix_q.size(), 1);
    if (pix_q.size() > 0) check("free_pix", 32'(pix_q[0]), 32'({8'd10, 7'd20}));
    check("free_col",  col_err, 0);
    check("free_busy", busy_cnt, 1);
    check("free_stdone", 32'(state_out), 32'd5);
    check("free_plotdone", 32'(plot), 32'd0);
    step();
    check("free_back", 32'(state_out), 32'd0);
    check("free_donelow", 32'(done), 32'd0);

    // FILL with swapped corners
    fill_exp = '{{8'd3, 7'd6}, {8'd4, 7'd6}, {8'd5, 7'd6},
                 {8'd3, 7'd7}, {8'd4, 7'd7}, {8'd5, 7'd7}};
    colour_in = 3'b010;
    pulse_go(8'd5, 2'b01);
    pulse_go(8'd7, 2'b01);
    check("fill_lx2", 32'(state_out), 32'd2);
    pulse_go(8'd3, 2'b01);
    pulse_go(8'd6, 2'b01);
    capture(20, 3'b010, 0);
    check("fill_npix", pix_q.size(), 6);
    check("fill_busy", busy_cnt, 6);
    for (int i = 0; i < 6; i++)
      if (i < pix_q.size()) check($sformatf("fill_pix%0d", i), 32'(pix_q[i]), 32'(fill_exp[i]));
    step();

    // OUTLINE 4x4
    colour_in = 3'b001;
    pulse_go(8'd0, 2'b10);
    pulse_go(8'd0, 2'b10);
    pulse_go(8'd3, 2'b10);
    pulse_go(8'd3, 2'b10);
    capture(40, 3'b001, 0);
    check("outl_busy", busy_cnt, 16);
    check("outl_npix", pix_q.size(), 12);
    interior = 0;
    foreach (pix_q[i])
      if (pix_q[i][14:7] inside {8'd1, 8'd2} && pix_q[i][6:0] inside {7'd1, 7'd2}) interior++;
    check("outl_interior", interior, 0);
    step();

    // Clamped FREE
    colour_in = 3'b110;
    pulse_go(8'd255, 2'b00);
    pulse_go(8'd127, 2'b00);
    capture(10, 3'b110, 0);
    check("clamp_npix", pix_q.size(), 1);
    if (pix_q.size() > 0) check("clamp_pix", 32'(pix_q[0]), 32'({8'd159, 7'd119}));
    step();

    // CLEAR full screen
    colour_in = 3'b000;
    pulse_go(8'd40, 2'b11);
    pulse_go(8'd50, 2'b00);
    capture(20000, 3'b000, 0);
    check("clr_npix", pix_q.size(), 19200);
    check("clr_busy", busy_cnt, 19200);
    if (pix_q.size() > 0) begin
      check("clr_first", 32'(pix_q[0]), 32'({8'd0, 7'd0}));
      check("clr_last",  32'(pix_q[pix_q.size()-1]), 32'({8'd159, 7'd119}));
    end
    step();

    // Reset in the 4th DRAW cycle of a 6-pixel FILL
    pulse_go(8'd5, 2'b01);
    pulse_go(8'd7, 2'b01);
    pulse_go(8'd3, 2'b01);
    pulse_go(8'd6, 2'b01);
    check("mid_draw", 32'(state_out), 32'd4);
    step();
    step();
    step();
    check("mid_x4", 32'({x, y}), 32'({8'd3, 7'd7}));
    Reset = 1'b1;
    step();
    Reset = 1'b0;
    check("mid_plot", 32'(plot), 32'd0);
    check("mid_state", 32'(state_out), 32'd0);
    check("mid_busy", 32'(busy), 32'd0);
    extra = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (plot || done || busy) extra++;
    end
    check("mid_quiet", extra, 0);

    // go toggling during FILL
    colour_in = 3'b011;
    pulse_go(8'd5, 2'b01);
    pulse_go(8'd7, 2'b01);
    pulse_go(8'd3, 2'b01);
    pulse_go(8'd6, 2'b01);
    capture(20, 3'b011, 1);
    check("gofill_npix", pix_q.size(), 6);
    check("gofill_col", col_err, 0);
    step();
    check("gofill_back", 32'(state_out), 32'd0);

    // Degenerate OUTLINE with mode/colour changes during DRAW
    colour_in = 3'b100;
    pulse_go(8'd2, 2'b10);
    pulse_go(8'd4, 2'b10);
    pulse_go(8'd6, 2'b10);
    pulse_go(8'd4, 2'b10);
    capture(20, 3'b100, 1);
    check("deg_npix", pix_q.size(), 5);
    check("deg_busy", busy_cnt, 5);
    check("deg_col", col_err, 0);
    for (int i = 0; i < 5; i++)
      if (i < pix_q.size()) check($sformatf("deg_pix%0d", i), 32'(pix_q[i]), 32'({8'(2 + i), 7'd4}));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
